ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
Read-side sequencer that sits directly downstream of the team's simple dual-port RAM: it drives the RAM read address and consumes the read data.
- On a start command it walks COUNT consecutive addresses from a base address, wrapping at DEPTH.
- It absorbs the RAM's 1-cycle read latency and presents the words as a valid/ready stream with full backpressure.
- Typical use: draining a frame or sample buffer written by another agent into a serializer, display driver or UART.

Parameters:
SIZE, 8, word width; must match the RAM's SIZE
DEPTH, 8, RAM entries; must match the RAM's DEPTH; AW = $clog2(DEPTH), CW = $clog2(DEPTH+1)

Ports:
clk  in  1  clock; the RAM read clock must be this same clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle command strobe; ignored while busy=1
start_addr  in  AW  first address to read
count  in  CW  number of words to read (0..DEPTH)
busy  out  1  high while a transfer is in progress
done  out  1  one-cycle pulse when the last word has been accepted
raddr  out  AW  to RAM raddr; driven from a register
read_data  in  SIZE  from RAM read_data; valid the cycle after raddr is sampled
out_data  out  SIZE  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready; a word transfers when out_valid and out_ready are both high at a clk edge

Behaviour:
- Reset (async assert, values held while rst=1): state=IDLE; busy=0; done=0; out_valid=0; out_data=0; raddr=0; internal buffer empty; pending flag=0; remaining=0.
- States:
  - IDLE -> READ on start with count>0. Latch addr_q=start_addr and remaining=count.
  - IDLE stays IDLE on start with count=0; done pulses the next cycle and busy stays 0.
  - READ -> DRAIN when the last address has been issued (remaining reaches 0).
  - DRAIN -> IDLE at the edge where the final word transfers. done=1 for exactly the following cycle; busy=0 from that same cycle.
- busy=1 in READ and DRAIN.
- Issue rule: at each edge in READ, issue raddr=addr_q (RAM samples it) iff remaining>0 and (occ + pend - pop) < 2, where:
  - occ = output buffer occupancy (0..2)
  - pend = 1 if a read is in flight
  - pop = a transfer occurs this edge
- On issue: pend<=1; addr_q <= (addr_q==DEPTH-1) ? 0 : addr_q+1, an explicit wrap that is valid for non-power-of-2 DEPTH; remaining decrements.
- Capture: when pend=1, read_data is written into the 2-entry buffer at the next edge. pend clears unless a new issue happens on the same edge.
- Output: out_data/out_valid come from the buffer head, which is registered with no combinational path from out_ready. out_data holds stable while out_valid=1 and out_ready=0.
- Latency: start accepted at edge E0, first issue at E1, out_valid=1 after E2.
- Throughput: with out_ready held high, 1 word/cycle, gap-free.
- Backpressure: the buffer never overflows and no word is dropped or duplicated.
- Order: words appear in address order, including across the wrap from DEPTH-1 to 0.
- Simultaneous events:
  - start during busy is ignored entirely.
  - Capture and pop on the same edge keep occ unchanged.
- Reset mid-transfer: everything returns to reset values and in-flight data is discarded.
- count>DEPTH is out of contract; the block must not hang (it simply reads count words with wrap).

Optional Feature:
RAM_STREAM_LAST_EN
- Defined: adds output out_last (1 bit, reset 0). It is stored alongside each buffered word and is high exactly with the final word of a transfer.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Decomposition:
- Package ram_stream_pkg: state enum {IDLE, READ, DRAIN} and a BUF_DEPTH=2 constant.
- One sub-module, stream_buf2: a 2-entry registered valid/ready buffer with push, pop, occ and head outputs. It is reused elsewhere for other latency-absorbing stages.

Test Plan:
- DEPTH=8, RAM preloaded mem[i]=i+0x10; start_addr=2, count=4, out_ready=1 -> out 0x12,0x13,0x14,0x15 on 4 consecutive cycles, first out_valid 2 cycles after start; done pulse 1 cycle after the 0x15 transfer.
- Wrap: start_addr=6, count=5 -> out 0x16,0x17,0x10,0x11,0x12.
- Backpressure: count=6, out_ready toggled by a random/1-of-3 pattern -> exact sequence, no loss or duplication, out_data stable while stalled, raddr never more than 2 words ahead of transfers.
- count=0 -> no out_valid, busy stays 0, done=1 one cycle after start; start asserted while busy -> ignored, original transfer completes unchanged.
- rst asserted mid-transfer (after 2 of 6 words) -> outputs zero immediately; a new start_addr=0, count=3 then yields 0x10,0x11,0x12.
- RAM_STREAM_LAST_EN defined -> out_last=1 only with the final word of each of the above transfers.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared state encoding and buffer depth for the RAM stream reader
package ram_stream_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/stream_buf2.sv
// stream_buf2: 2-entry registered valid/ready buffer (head is a register, no ready-to-data path)
// Ports: push/din write an entry; pop removes the head (caller gates with valid);
// occ = entries held; valid = occ!=0; head = oldest entry.
module stream_buf2
  import ram_stream_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic [W-1:0]                       din,
  input  logic                               pop,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     occ,
  output logic                               valid,
  output logic [W-1:0]                       head
);
  logic [W-1:0] tail;
  assign valid = occ != '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      occ <= occ + $bits(occ)'(push) - $bits(occ)'(pop);
      if (pop && occ == $bits(occ)'(2))
        head <= tail;
      else if (push && (occ == '0 || pop))
        head <= din;
      if (push && (pop ? occ == $bits(occ)'(2) : occ == $bits(occ)'(1)))
        tail <= din;
    end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks COUNT RAM addresses from a base (wrapping at DEPTH) and streams the words out
// Ports: start/start_addr/count launch a transfer (ignored while busy); busy, done (1-cycle pulse);
// raddr/read_data connect to the RAM read port (1-cycle latency); out_data/out_valid/out_ready stream.
// Build option RAM_STREAM_LAST_EN adds out_last, high with the final word of each transfer.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   start_addr,
  input  logic [CW-1:0]   count,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   raddr,
  input  logic [SIZE-1:0] read_data,
  output logic [SIZE-1:0] out_data,
`ifdef RAM_STREAM_LAST_EN
  output logic            out_last,
`endif
  output logic            out_valid,
  input  logic            out_ready
);
`ifdef RAM_STREAM_LAST_EN
  localparam int BW = SIZE + 1;
`else
  localparam int BW = SIZE;
`endif
  state_t state, state_n;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] remaining;
  logic pend, pend_last, pop, issue, last_issue, final_pop, launch;
  logic [1:0] occ;
  logic [BW-1:0] din, head;
  assign raddr = addr_q;
  assign pop = out_valid && out_ready;
  assign launch = state == IDLE && start && count != '0;
  // Issue only if the word still fits once in-flight and departing words are accounted for.
  assign issue = state == READ && remaining != '0 &&
                 ({1'b0, occ} + 3'(pend)) < (3'(BUF_DEPTH) + 3'(pop));
  assign last_issue = issue && remaining == CW'(1);
  assign final_pop = state == DRAIN && pop && occ == 2'd1 && !pend;
  always_comb begin
    state_n = launch ? READ : last_issue ? DRAIN : final_pop ? IDLE : state;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q    <= '0;
      remaining <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= (state == IDLE && start && count == '0) || final_pop;
      pend      <= issue;
      pend_last <= last_issue;
      if (launch) begin
        addr_q    <= start_addr;
        remaining <= count;
      end else if (issue) begin
        addr_q    <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
        remaining <= remaining - CW'(1);
      end
    end
`ifdef RAM_STREAM_LAST_EN
  assign din = {pend_last, read_data};
  assign out_last = head[SIZE];
`else
  assign din = read_data;
`endif
  assign out_data = head[SIZE-1:0];
  stream_buf2 #(.W(BW)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (pend),
    .din   (din),
    .pop   (pop),
    .occ   (occ),
    .valid (out_valid),
    .head  (head)
  );
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: table-driven and randomized checks of ram_stream_reader against a queue model
module tb_ram_stream_reader;
  localparam int SIZE = 8, DEPTH = 8, AW = 3, CW = 4;
  logic clk = 0, rst = 0, start = 0, out_ready = 0;
  logic [AW-1:0] start_addr = 0, raddr;
  logic [CW-1:0] count = 0;
  logic busy, done, out_valid;
  logic [SIZE-1:0] read_data, out_data;
`ifdef RAM_STREAM_LAST_EN
  logic out_last;
`endif
  logic [SIZE-1:0] mem [DEPTH];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = SIZE'(i + 'h10);
  always @(posedge clk) read_data <= mem[raddr];

  ram_stream_reader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .busy(busy), .done(done), .raddr(raddr), .read_data(read_data), .out_data(out_data),
`ifdef RAM_STREAM_LAST_EN
    .out_last(out_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_raddr"}, 32'(raddr), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
`ifdef RAM_STREAM_LAST_EN
    chk({tag, "_last"}, 32'(out_last), 0);
`endif
  endtask

  // mode: 0 ready always, 1 random ready (2 of 3), 2 ready one cycle in three
  task automatic run_xfer(int sa, int cnt, int mode, bit inject);
    int exp_q[$];
    int k, last_k, first_k, first_v, ndone, ntx, max_ahead, ahead;
    bit stalled, any_busy;
    logic [SIZE-1:0] prev_d;
    for (int i = 0; i < cnt; i++) exp_q.push_back(((sa + i) % DEPTH) + 'h10);
    @(negedge clk);
    start = 1; start_addr = AW'(sa); count = CW'(cnt); out_ready = 0;
    last_k = (cnt == 0) ? 0 : -1;
    first_k = -1; first_v = -1; ndone = 0; ntx = 0; max_ahead = 0;
    stalled = 0; any_busy = 0; prev_d = '0;
    for (k = 1; k < 200; k++) begin
      @(negedge clk);
      start = inject && k == 4;
      if (start) begin start_addr = AW'(sa + 3); count = CW'(2); end
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom % 3 != 0) : (k % 3 == 0);
      #1;
      if (done) ndone++;
      if (busy) any_busy = 1;
      if (last_k >= 0 && k == last_k + 1) begin
        chk("done_pulse", 32'(done), 1);
        chk("busy_after_done", 32'(busy), 0);
        break;
      end
      if (busy && cnt < DEPTH) begin
        ahead = ((int'(raddr) - sa + DEPTH) % DEPTH) - ntx;
        if (ahead > max_ahead) max_ahead = ahead;
      end
      if (stalled) chk("stall_hold", 32'(out_data), 32'(prev_d));
      if (out_valid && first_v < 0) first_v = k;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 32'(out_data), 32'hFFFF_FFFF);
        else begin
          chk("word", 32'(out_data), 32'(exp_q.pop_front()));
`ifdef RAM_STREAM_LAST_EN
          chk("out_last", 32'(out_last), 32'(exp_q.size() == 0));
`endif
          ntx++;
          if (first_k < 0) first_k = k;
          if (exp_q.size() == 0) last_k = k;
        end
      end
      stalled = out_valid && !out_ready;
      prev_d = out_data;
    end
    start = 0; out_ready = 0;
    chk("completed_in_budget", 32'(k < 200), 1);
    chk("done_count", 32'(ndone), 1);
    chk("words_moved", 32'(ntx), 32'(cnt));
    if (cnt == 0) begin
      chk("cnt0_no_valid", 32'(first_v), 32'hFFFF_FFFF);
      chk("cnt0_no_busy", 32'(any_busy), 0);
    end else chk("first_valid_cycle", 32'(first_v), 3);
    if (mode == 0 && cnt > 0) chk("gap_free", 32'(last_k - first_k), 32'(cnt - 1));
    if (cnt > 0 && cnt < DEPTH) chk("raddr_ahead_max", 32'(max_ahead > 2 ? max_ahead : 0), 0);
  endtask

  typedef struct {
    int sa; int cnt; int mode; bit inject; int exp_first;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int ntx, n;
    vecs[0] = '{2, 4, 0, 0, 'h12};
    vecs[1] = '{6, 5, 0, 0, 'h16};
    vecs[2] = '{1, 6, 2, 0, 'h11};
    vecs[3] = '{3, 6, 1, 0, 'h13};
    vecs[4] = '{0, 0, 0, 0, 0};
    vecs[5] = '{5, 6, 2, 1, 'h15};
    vecs[6] = '{7, 8, 1, 0, 'h17};
    vecs[7] = '{4, 10, 0, 0, 'h14};
    #2 rst = 1;
    repeat (2) @(negedge clk);
    #1 chk_idle("reset");
    @(negedge clk) rst = 0;
    foreach (vecs[i]) begin
      if (vecs[i].cnt > 0)
        chk("table_first_word_model", 32'((vecs[i].sa % DEPTH) + 'h10), 32'(vecs[i].exp_first));
      run_xfer(vecs[i].sa, vecs[i].cnt, vecs[i].mode, vecs[i].inject);
    end
    @(negedge clk);
    start = 1; start_addr = 1; count = 6; out_ready = 1;
    ntx = 0; n = 0;
    while (ntx < 2 && n < 20) begin
      @(negedge clk); start = 0; #1;
      if (out_valid && out_ready) ntx++;
      n++;
    end
    chk("rst_mid_reached_two", 32'(ntx), 2);
    @(negedge clk) rst = 1;
    #1 chk_idle("rst_mid");
    @(negedge clk) rst = 0;
    out_ready = 0;
    run_xfer(0, 3, 0, 0);
    repeat (6) run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), $urandom_range(0, 2), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
